fp_mul_param: RTL and testbench

FP_MUL_PARAM -- requirements
Module: fp_mul_param

---
 rtl/fp_mul_pkg.sv | 53 +++++
 rtl/fp_mul_iter_mant.sv | 51 +++++
 rtl/fp_mul_param.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fp_mul_param.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the iterative floating-point multiplier.
package fp_mul_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLASSIFY,
      S_MUL,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      C_ZERO,
      C_SUB,
      C_NORM,
      C_INF,
      C_NAN
   } cls_t;

   localparam logic [2:0] EXC_NONE    = 3'b000;
   localparam logic [2:0] EXC_UNDER   = 3'b001;
   localparam logic [2:0] EXC_OVER    = 3'b010;
   localparam logic [2:0] EXC_INF     = 3'b011;
   localparam logic [2:0] EXC_NAN     = 3'b100;
   localparam logic [2:0] EXC_INEXACT = 3'b101;

   localparam logic RND_RNE = 1'b0;
   localparam logic RND_RTZ = 1'b1;

   function automatic logic [63:0] bias_of(input int exp_w);
      return (64'd1 << (exp_w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] qnan_of(input int exp_w, input int man_w);
      return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
   endfunction

   // Operand is passed zero-extended to 64 bits.
   function automatic cls_t classify(input int exp_w, input int man_w,
                                     input logic [63:0] x);
      logic [63:0] e;
      logic [63:0] f;
      logic [63:0] emax;
      emax = (64'd1 << exp_w) - 64'd1;
      e    = (x >> man_w) & emax;
      f    = x & ((64'd1 << man_w) - 64'd1);
      if (e == emax) return (|f) ? C_NAN : C_INF;
      if (~|e) return (|f) ? C_SUB : C_ZERO;
      return C_NORM;
   endfunction

endpackage

// File: rtl/fp_mul_iter_mant.sv
// Radix-2 shift-add significand multiplier; one product bit per cycle,
// the first step is folded into the start cycle.
module fp_mul_iter_mant
   import fp_mul_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           CLK,
   input  logic           RSTn,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           done,
   output logic [2*N-1:0] prod
);

   localparam int CW = $clog2(N + 1);

   logic [N-1:0]   mcand;
   logic [N-1:0]   addend;
   logic [2*N-1:0] src;
   logic [2*N-1:0] step;
   logic [N:0]     sum;
   logic [CW-1:0]  cnt;

   always_comb begin
      src    = start ? {{N{1'b0}}, b} : prod;
      addend = (start ? a : mcand) & {N{src[0]}};
      sum    = {1'b0, src[2*N-1:N]} + {1'b0, addend};
      step   = {sum, src[N-1:1]};
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         mcand <= '0;
         prod  <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else if (start) begin
         mcand <= a;
         prod  <= step;
         cnt   <= CW'(N - 1);
         done  <= (N == 1);
      end else if (cnt != '0) begin
         prod <= step;
         cnt  <= cnt - 1'b1;
         done <= (cnt == CW'(1));
      end
   end

endmodule

// File: rtl/fp_mul_param.sv
// Multi-cycle parameterised FP multiplier with RNE/RTZ rounding.
// Define FP_MUL_DENORM_EN for gradual underflow; otherwise subnormals flush.
module fp_mul_param
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   op_a,
   input  logic [EXP_W+MAN_W:0]   op_b,
   input  logic                   rnd_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [2:0]             exc,
   output logic                   busy
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int N  = MAN_W + 1;
   localparam int PW = 2 * N;
   localparam int EW = EXP_W + 2;

   localparam logic [W-1:0] QNAN = W'(qnan_of(EXP_W, MAN_W));
   localparam logic signed [EW-1:0] BIAS = $signed(EW'(bias_of(EXP_W)));
   localparam logic signed [EW-1:0] EMAX =
      $signed(EW'((64'd1 << EXP_W) - 64'd1));
   localparam logic signed [EW-1:0] ONE = $signed(EW'(1));

   state_t state, state_nx;

   logic [W-1:0] a_q, b_q;
   logic         rnd_q;
   logic         accept;
   logic         sign;

   cls_t cls_a, cls_b;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic is_nan, is_inf, is_zero, is_reg;

   logic [EXP_W-1:0]     ea, eb;
   logic signed [EW-1:0] exp_r;
   logic [N-1:0]         ma, mb;

   logic          mul_start, mul_done;
   logic [PW-1:0] prod;

   logic signed [EW-1:0] lz, exp_n, exp_d;
   logic [PW-1:0]        jp, sh;
   logic                 found, lost, tiny_d;
   logic [N-1:0]         mant_d;
   logic                 g_d, s_d;

   logic signed [EW-1:0] exp_q;
   logic [N-1:0]         mant_q;
   logic                 g_q, s_q, tiny_q;

   logic                 inc, inexact;
   logic [N:0]           sum_r;
   logic [N-1:0]         mant_f;
   logic signed [EW-1:0] exp_f;
   logic [EXP_W-1:0]     efld;
   logic [W-1:0]         res_nx;
   logic [2:0]           exc_nx;

   logic [W-1:0] res_q;
   logic [2:0]   exc_q;
   logic         ov_q;

   assign accept    = in_valid & in_ready;
   assign in_ready  = RSTn & (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign out_valid = ov_q;
   assign result    = res_q;
   assign exc       = ov_q ? exc_q : EXC_NONE;
   assign sign      = a_q[W-1] ^ b_q[W-1];

   always_comb begin
      cls_a = classify(EXP_W, MAN_W, 64'(a_q));
      cls_b = classify(EXP_W, MAN_W, 64'(b_q));
`ifdef FP_MUL_DENORM_EN
      a_zero = (cls_a == C_ZERO);
      b_zero = (cls_b == C_ZERO);
`else
      a_zero = (cls_a == C_ZERO) || (cls_a == C_SUB);
      b_zero = (cls_b == C_ZERO) || (cls_b == C_SUB);
`endif
      a_inf   = (cls_a == C_INF);
      b_inf   = (cls_b == C_INF);
      a_nan   = (cls_a == C_NAN);
      b_nan   = (cls_b == C_NAN);
      is_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      is_inf  = ~is_nan & (a_inf | b_inf);
      is_zero = ~is_nan & ~is_inf & (a_zero | b_zero);
      is_reg  = ~(is_nan | is_inf | is_zero);
   end

   // Subnormals carry a hidden 0 and act as exponent 1.
   always_comb begin
      ea    = a_q[W-2:MAN_W];
      eb    = b_q[W-2:MAN_W];
      ma    = {|ea, a_q[MAN_W-1:0]};
      mb    = {|eb, b_q[MAN_W-1:0]};
      exp_r = $signed({2'b00, (|ea) ? ea : EXP_W'(1)})
            + $signed({2'b00, (|eb) ? eb : EXP_W'(1)})
            - BIAS;
   end

   assign mul_start = (state == S_CLASSIFY) & is_reg;

   fp_mul_iter_mant #(
      .N(N)
   ) u_mant (
      .CLK  (CLK),
      .RSTn (RSTn),
      .start(mul_start),
      .a    (ma),
      .b    (mb),
      .done (mul_done),
      .prod (prod)
   );

   always_ff @(posedge CLK) begin
      if (!RSTn) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:     if (accept) state_nx = S_CLASSIFY;
         S_CLASSIFY: state_nx = is_reg ? S_MUL : S_DONE;
         S_MUL:      if (mul_done) state_nx = S_NORM;
         S_NORM:     state_nx = S_ROUND;
         S_ROUND:    state_nx = S_DONE;
         S_DONE:     if (ov_q & out_ready) state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // Left-justify; exponent gains 1 for a 2.x product, loses 1 per extra zero.
   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int i = PW - 1; i >= 0; i--) begin
         if (!found && prod[i]) begin
            lz    = EW'(PW - 1 - i);
            found = 1'b1;
         end
      end
      jp     = prod << lz;
      exp_n  = exp_r + ONE - lz;
      sh     = jp;
      lost   = 1'b0;
      tiny_d = 1'b0;
      exp_d  = exp_n;
`ifdef FP_MUL_DENORM_EN
      if (exp_n < ONE) begin
         tiny_d = 1'b1;
         exp_d  = ONE;
         if (int'(ONE - exp_n) >= PW) begin
            sh   = '0;
            lost = |jp;
         end else begin
            sh   = jp >> (ONE - exp_n);
            lost = |(jp & ~({PW{1'b1}} << (ONE - exp_n)));
         end
      end
`else
      if (exp_n < ONE) tiny_d = 1'b1;
`endif
      mant_d = sh[PW-1 -: N];
      g_d    = sh[PW-1-N];
      s_d    = (|sh[PW-2-N:0]) | lost;
   end

   always_comb begin
      inc     = (rnd_q == RND_RNE) & g_q & (mant_q[0] | s_q);
      inexact = g_q | s_q;
      sum_r   = {1'b0, mant_q} + {{N{1'b0}}, inc};
      if (sum_r[N]) begin
         mant_f = sum_r[N:1];
         exp_f  = exp_q + ONE;
      end else begin
         mant_f = sum_r[N-1:0];
         exp_f  = exp_q;
      end
      efld   = mant_f[N-1] ? exp_f[EXP_W-1:0] : '0;
      res_nx = {sign, efld, mant_f[MAN_W-1:0]};
      exc_nx = inexact ? EXC_INEXACT : EXC_NONE;
      if (tiny_q) begin
`ifdef FP_MUL_DENORM_EN
         exc_nx = inexact ? EXC_UNDER : EXC_NONE;
`else
         res_nx = {sign, {(W-1){1'b0}}};
         exc_nx = EXC_UNDER;
`endif
      end else if (exp_f >= EMAX) begin
         exc_nx = EXC_OVER;
         if (rnd_q == RND_RTZ)
            res_nx = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         else
            res_nx = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         a_q    <= '0;
         b_q    <= '0;
         rnd_q  <= RND_RNE;
         exp_q  <= '0;
         mant_q <= '0;
         g_q    <= 1'b0;
         s_q    <= 1'b0;
         tiny_q <= 1'b0;
         res_q  <= '0;
         exc_q  <= EXC_NONE;
      end else begin
         if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            rnd_q <= rnd_mode;
         end
         if (state == S_CLASSIFY) begin
            unique case (1'b1)
               is_nan: begin
                  res_q <= QNAN;
                  exc_q <= EXC_NAN;
               end
               is_inf: begin
                  res_q <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  exc_q <= EXC_INF;
               end
               is_zero: begin
                  res_q <= {sign, {(W-1){1'b0}}};
                  exc_q <= EXC_NONE;
               end
               default: ;
            endcase
         end
         if (state == S_NORM) begin
            exp_q  <= exp_d;
            mant_q <= mant_d;
            g_q    <= g_d;
            s_q    <= s_d;
            tiny_q <= tiny_d;
         end
         if (state == S_ROUND) begin
            res_q <= res_nx;
            exc_q <= exc_nx;
         end
      end
   end

   // Result becomes visible one cycle after DONE is entered.
   always_ff @(posedge CLK) begin
      if (!RSTn)                          ov_q <= 1'b0;
      else if (state == S_DONE && !ov_q)  ov_q <= 1'b1;
      else if (ov_q && out_ready)         ov_q <= 1'b0;
   end

endmodule

// File: tb/tb_fp_mul_param.sv
// Directed-vector bench for fp_mul_param at EXP_W=8, MAN_W=7.
// Expectations follow FP_MUL_DENORM_EN when it is defined for the build.
module tb_fp_mul_param;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic        rnd_mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic [2:0]  exc;
   logic        busy;

   int errors = 0;
   int checks = 0;

   fp_mul_param #(
      .EXP_W(8),
      .MAN_W(7)
   ) dut (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op_a     (op_a),
      .op_b     (op_b),
      .rnd_mode (rnd_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .exc      (exc),
      .busy     (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic rnd,
                         input logic [15:0] eres, input logic [2:0] eexc,
                         input int elat, input int hold);
      int lat;
      int w;
      logic exc_bad;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      chk({tag, " in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      rnd_mode = rnd;
      tick();
      in_valid = 1'b0;
      op_a     = 16'($urandom);
      op_b     = 16'($urandom);
      rnd_mode = 1'($urandom);
      lat      = 0;
      exc_bad  = 1'b0;
      while (!out_valid && lat < 40) begin
         if (exc !== 3'b000) exc_bad = 1'b1;
         tick();
         lat++;
      end
      chk({tag, " latency"}, lat, elat);
      chk({tag, " exc_idle"}, exc_bad, 0);
      chk({tag, " result"}, result, eres);
      chk({tag, " exc"}, exc, eexc);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, " hold_res"}, result, eres);
         chk({tag, " hold_exc"}, exc, eexc);
         chk({tag, " hold_vld"}, out_valid, 1);
         chk({tag, " hold_rdy"}, in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " drop_vld"}, out_valid, 0);
      chk({tag, " drop_exc"}, exc, 0);
      chk({tag, " rdy_back"}, in_ready, 1);
   endtask

   initial begin
      int rises;

      repeat (3) tick();
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst result", result, 0);
      chk("rst exc", exc, 0);
      chk("rst busy", busy, 0);
      RSTn = 1'b1;
      tick();
      chk("post_rst in_ready", in_ready, 1);
      chk("post_rst busy", busy, 0);

      run_op("1.5x2",      16'h3FC0, 16'h4000, 1'b0, 16'h4040, 3'b000, 12, 5);
      run_op("neg1.5x2",   16'hBFC0, 16'h4000, 1'b0, 16'hC040, 3'b000, 12, 0);
      run_op("sq_rne",     16'h3F81, 16'h3F81, 1'b0, 16'h3F82, 3'b101, 12, 0);
      run_op("sq_rtz",     16'h3F81, 16'h3F81, 1'b1, 16'h3F82, 3'b101, 12, 0);
      run_op("up_rne",     16'h3FC1, 16'h3FC1, 1'b0, 16'h4012, 3'b101, 12, 0);
      run_op("up_rtz",     16'h3FC1, 16'h3FC1, 1'b1, 16'h4011, 3'b101, 12, 0);
      run_op("tie_odd",    16'h3FC0, 16'h3F81, 1'b0, 16'h3FC2, 3'b101, 12, 0);
      run_op("tie_even",   16'h3FC0, 16'h3F83, 1'b0, 16'h3FC4, 3'b101, 12, 0);
      run_op("carry_out",  16'h3FFE, 16'h3F81, 1'b0, 16'h4000, 3'b101, 12, 0);
      run_op("ovf_rne",    16'h7F00, 16'h4000, 1'b0, 16'h7F80, 3'b010, 12, 0);
      run_op("ovf_rtz",    16'h7F00, 16'h4000, 1'b1, 16'h7F7F, 3'b010, 12, 0);
      run_op("inf_x0",     16'h7F80, 16'h0000, 1'b0, 16'h7FC0, 3'b100, 2, 0);
      run_op("nan_op",     16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 3'b100, 2, 0);
      run_op("ninf_x2",    16'hFF80, 16'h4000, 1'b0, 16'hFF80, 3'b011, 2, 0);
      run_op("nzero_x2",   16'h8000, 16'h4000, 1'b0, 16'h8000, 3'b000, 2, 0);
`ifdef FP_MUL_DENORM_EN
      run_op("tiny_res",   16'h0080, 16'h3F00, 1'b0, 16'h0040, 3'b000, 12, 0);
      run_op("sub_in",     16'h0040, 16'h4000, 1'b0, 16'h0080, 3'b000, 12, 0);
`else
      run_op("tiny_res",   16'h0080, 16'h3F00, 1'b0, 16'h0000, 3'b001, 12, 0);
      run_op("sub_in",     16'h0040, 16'h4000, 1'b0, 16'h0000, 3'b000, 2, 0);
`endif

      in_valid = 1'b1;
      op_a     = 16'h3FC0;
      op_b     = 16'h4000;
      rnd_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("midrst busy_before", busy, 1);
      RSTn = 1'b0;
      tick();
      chk("midrst busy", busy, 0);
      chk("midrst out_valid", out_valid, 0);
      chk("midrst in_ready", in_ready, 0);
      RSTn  = 1'b1;
      rises = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) rises++;
      end
      chk("midrst no_output", rises, 0);
      run_op("after_rst",  16'h3F81, 16'h3F81, 1'b0, 16'h3F82, 3'b101, 12, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
